// File: rtl/timer_ctrl.sv
// timer_ctrl: countdown-timer sequencer for the alarm/timer path.
// Holds the programmed hh:mm:ss value (packed BCD), edits it from user
// pulses in SET, counts it down once per tick_1hz in RUN and latches an
// alarm when the count reaches 00:00:00.
//
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   tick_1hz          one-cycle pulse per second
//   set_en            level: edit mode request
//   set_sel[1:0]      0 = seconds, 1 = minutes, 2 = hours, 3 = none
//   btn_up/btn_down   increment / decrement the selected field
//   btn_start         start or resume
//   btn_pause         pause
//   btn_desactivar    abort, or clear the alarm
//   out_seg/min/hora  BCD seconds, minutes, hours (registered)
//   running           1 exactly while estado = RUN
//   alarm             latched alarm flag
//   estado[2:0]       IDLE=0, SET=1, RUN=2, PAUSE=3, ALARM=4
module timer_ctrl #(
  parameter logic [7:0] MAX_HOURS = 8'h23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_desactivar,
  output logic [7:0] out_seg,
  output logic [7:0] out_min,
  output logic [7:0] out_hora,
  output logic       running,
  output logic       alarm,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hora_q, hora_d;
  logic       alarm_d;
  logic       running_d;

  // BCD increment with wrap from max_v back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    logic [3:0] hi;
    if (v == max_v) return '0;
    if (v[3:0] == 4'd9) begin
      hi = v[7:4] + 4'd1;
      return {hi, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement with wrap from 00 to max_v.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
    logic [3:0] hi;
    if (v == 8'h00) return max_v;
    if (v[3:0] == 4'd0) begin
      hi = v[7:4] - 4'd1;
      return {hi, 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    min_d   = min_q;
    hora_d  = hora_q;
    alarm_d = alarm;

    unique case (state_q)
      IDLE: begin
        if (set_en) begin
          state_d = SET;
        end else if (btn_start && ({hora_q, min_q, seg_q} != 24'h0)) begin
          state_d = RUN;
        end
      end

      SET: begin
        if (!set_en) begin
          state_d = IDLE;
        end else if (btn_up != btn_down) begin
          unique case (set_sel)
            2'd0: seg_d  = btn_up ? bcd_inc(seg_q, 8'h59)      : bcd_dec(seg_q, 8'h59);
            2'd1: min_d  = btn_up ? bcd_inc(min_q, 8'h59)      : bcd_dec(min_q, 8'h59);
            2'd2: hora_d = btn_up ? bcd_inc(hora_q, MAX_HOURS) : bcd_dec(hora_q, MAX_HOURS);
            default: ;
          endcase
        end
      end

      RUN: begin
        if (btn_desactivar) begin
          state_d = IDLE;
          seg_d   = '0;
          min_d   = '0;
          hora_d  = '0;
        end else if (btn_pause) begin
          state_d = PAUSE;
        end else if (tick_1hz) begin
          // Borrow chain: seconds always step; minutes only when seconds
          // were 00; hours only when both were 00.
          seg_d = bcd_dec(seg_q, 8'h59);
          if (seg_q == 8'h00) begin
            min_d = bcd_dec(min_q, 8'h59);
            if (min_q == 8'h00) hora_d = bcd_dec(hora_q, MAX_HOURS);
          end
          // Expiry is decided on the decremented value so ALARM appears on
          // the same edge that shows 00:00:00.
          if ({hora_d, min_d, seg_d} == 24'h0) begin
            state_d = ALARM;
            alarm_d = 1'b1;
          end
        end
      end

      PAUSE: begin
        if (btn_desactivar) begin
          state_d = IDLE;
          seg_d   = '0;
          min_d   = '0;
          hora_d  = '0;
        end else if (btn_start) begin
          state_d = RUN;
        end
      end

      ALARM: begin
        seg_d  = '0;
        min_d  = '0;
        hora_d = '0;
        if (btn_desactivar) begin
          state_d = IDLE;
          alarm_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        seg_d   = '0;
        min_d   = '0;
        hora_d  = '0;
        alarm_d = 1'b0;
      end
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seg_q   <= '0;
      min_q   <= '0;
      hora_q  <= '0;
      alarm   <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      min_q   <= min_d;
      hora_q  <= hora_d;
      alarm   <= alarm_d;
      running <= running_d;
    end
  end

  assign out_seg  = seg_q;
  assign out_min  = min_q;
  assign out_hora = hora_q;
  assign estado   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios followed by a
// random phase, all compared every cycle against a reference model that
// keeps the time as decimal fields and counts down on total seconds.
module tb_timer_ctrl;

  localparam int MAX_H = 23;
  localparam int S_IDLE = 0, S_SET = 1, S_RUN = 2, S_PAUSE = 3, S_ALARM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_desactivar = 1'b0;
  logic [7:0] out_seg, out_min, out_hora;
  logic       running, alarm;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_state, m_h, m_m, m_s;
  bit m_alarm;

  timer_ctrl #(.MAX_HOURS(8'h23)) dut (
    .clk(clk),
    .reset(reset),
    .tick_1hz(tick_1hz),
    .set_en(set_en),
    .set_sel(set_sel),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_desactivar(btn_desactivar),
    .out_seg(out_seg),
    .out_min(out_min),
    .out_hora(out_hora),
    .running(running),
    .alarm(alarm),
    .estado(estado)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".seg"},     out_seg,            to_bcd(m_s));
    chk({tag, ".min"},     out_min,            to_bcd(m_m));
    chk({tag, ".hora"},    out_hora,           to_bcd(m_h));
    chk({tag, ".estado"},  {5'd0, estado},     8'(m_state));
    chk({tag, ".running"}, {7'd0, running},    {7'd0, (m_state == S_RUN)});
    chk({tag, ".alarm"},   {7'd0, alarm},      {7'd0, m_alarm});
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_h = 0; m_m = 0; m_s = 0; m_alarm = 0;
  endtask

  function automatic int wrap(input int v, input int lim);
    return (v % lim + lim) % lim;
  endfunction

  // Behavioural rules: fields edited modulo their range, countdown on total seconds.
  task automatic model_step(input bit t, se, input int sel, input bit up, dn, st, pa, de);
    int total, d;
    total = m_h * 3600 + m_m * 60 + m_s;
    d = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
    case (m_state)
      S_IDLE: begin
        if (se) m_state = S_SET;
        else if (st && total != 0) m_state = S_RUN;
      end
      S_SET: begin
        if (!se) m_state = S_IDLE;
        else if (sel == 0) m_s = wrap(m_s + d, 60);
        else if (sel == 1) m_m = wrap(m_m + d, 60);
        else if (sel == 2) m_h = wrap(m_h + d, MAX_H + 1);
      end
      S_RUN: begin
        if (de) begin
          m_state = S_IDLE; m_h = 0; m_m = 0; m_s = 0;
        end else if (pa) begin
          m_state = S_PAUSE;
        end else if (t) begin
          total -= 1;
          m_h = total / 3600; m_m = (total / 60) % 60; m_s = total % 60;
          if (total == 0) begin
            m_state = S_ALARM; m_alarm = 1;
          end
        end
      end
      S_PAUSE: begin
        if (de) begin
          m_state = S_IDLE; m_h = 0; m_m = 0; m_s = 0;
        end else if (st) begin
          m_state = S_RUN;
        end
      end
      default: begin
        if (de) begin
          m_state = S_IDLE; m_alarm = 0;
        end
      end
    endcase
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit t, se, input logic [1:0] sel, input bit up, dn, st, pa, de);
    tick_1hz = t; set_en = se; set_sel = sel; btn_up = up; btn_down = dn;
    btn_start = st; btn_pause = pa; btn_desactivar = de;
    model_step(t, se, int'(sel), up, dn, st, pa, de);
    @(posedge clk);
    #1;
    tick_1hz = 0; btn_up = 0; btn_down = 0; btn_start = 0; btn_pause = 0; btn_desactivar = 0;
    check_all("cyc");
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst");
  endtask

  task automatic program_value(input logic [1:0] sel, input int n);
    cyc(0, 1, sel, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc(0, 1, sel, 1, 0, 0, 0, 0);
    cyc(0, 0, 2'd3, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    do_reset();

    // Minute edits: 61 ups pass 09->10 and 59->00, then down across 00.
    cyc(0, 1, 2'd1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 61; i++) begin
      cyc(0, 1, 2'd1, 1, 0, 0, 0, 0);
      if (i == 9) chk("min_09_to_10", out_min, 8'h10);
      if (i == 59) chk("min_59_to_00", out_min, 8'h00);
    end
    chk("min_after_61", out_min, 8'h01);
    cyc(0, 1, 2'd1, 0, 1, 0, 0, 0);
    chk("min_dn_10", out_min, 8'h00);
    cyc(0, 1, 2'd1, 0, 1, 0, 0, 0);
    chk("min_dn_wrap", out_min, 8'h59);
    cyc(0, 1, 2'd1, 1, 1, 0, 0, 0);
    chk("min_up_dn_same", out_min, 8'h59);
    cyc(0, 1, 2'd1, 0, 0, 1, 0, 0);
    chk("set_ignores_start", {5'd0, estado}, 8'd1);
    cyc(0, 0, 2'd3, 0, 0, 0, 0, 0);

    // 00:01:00 countdown to alarm.
    do_reset();
    program_value(2'd1, 1);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    chk("run_state", {5'd0, estado}, 8'd2);
    cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("borrow_seg", out_seg, 8'h59);
    chk("borrow_min", out_min, 8'h00);
    for (int i = 0; i < 59; i++) cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("expire_seg", out_seg, 8'h00);
    chk("expire_estado", {5'd0, estado}, 8'd4);
    chk("expire_alarm", {7'd0, alarm}, 8'd1);

    // 01:00:00 borrow through hours; hours down wrap.
    do_reset();
    program_value(2'd2, 1);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("hr_borrow_h", out_hora, 8'h00);
    chk("hr_borrow_m", out_min, 8'h59);
    chk("hr_borrow_s", out_seg, 8'h59);
    cyc(0, 0, 2'd3, 0, 0, 0, 0, 1);
    chk("abort_idle", {5'd0, estado}, 8'd0);
    cyc(0, 1, 2'd2, 0, 0, 0, 0, 0);
    cyc(0, 1, 2'd2, 0, 1, 0, 0, 0);
    chk("hora_dn_wrap", out_hora, 8'h23);
    cyc(0, 1, 2'd2, 1, 0, 0, 0, 0);
    chk("hora_up_wrap", out_hora, 8'h00);
    cyc(0, 0, 2'd3, 0, 0, 0, 0, 0);

    // Pause with coincident tick, frozen value, resume.
    do_reset();
    program_value(2'd0, 5);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    cyc(1, 0, 2'd3, 0, 0, 0, 1, 0);
    chk("pause_state", {5'd0, estado}, 8'd3);
    chk("pause_seg", out_seg, 8'h05);
    for (int i = 0; i < 10; i++) cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("pause_frozen", out_seg, 8'h05);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("resume_seg", out_seg, 8'h04);

    // Alarm holds, clears on desactivar; start at zero ignored.
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("alarm_state", {5'd0, estado}, 8'd4);
    for (int i = 0; i < 100; i++) cyc(1, 1, 2'd0, 1, 0, 1, 1, 0);
    chk("alarm_hold", {7'd0, alarm}, 8'd1);
    cyc(0, 0, 2'd3, 0, 0, 0, 0, 1);
    chk("alarm_clear", {7'd0, alarm}, 8'd0);
    chk("alarm_to_idle", {5'd0, estado}, 8'd0);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    chk("start_zero_ignored", {5'd0, estado}, 8'd0);

    // Reset mid-run at 00:10:00.
    do_reset();
    program_value(2'd1, 10);
    cyc(0, 0, 2'd3, 0, 0, 1, 0, 0);
    cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 2'd3, 0, 0, 0, 0, 0);
    chk("no_resume", {5'd0, estado}, 8'd0);

    // Random phase.
    begin
      bit se_lvl;
      se_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 24) == 0) se_lvl = !se_lvl;
        cyc($urandom_range(0, 2) == 0, se_lvl, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Countdown-timer sequencer for the alarm/timer path. It owns the programmed hh:mm:ss value, edits it from user pulses, and decrements it once per one-second tick. It raises a latched alarm when the count reaches 00:00:00 and clears it on the deactivate button. Outputs feed the timer display register and the VGA overlay as packed BCD bytes.

## Interface

Parameters:
- MAX_HOURS, 8'h23: largest legal hours value, BCD.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- tick_1hz  in  1  one-cycle pulse, once per second
- set_en  in  1  level: edit mode request
- set_sel  in  2  field select: 0 = seconds, 1 = minutes, 2 = hours, 3 = none
- btn_up  in  1  one-cycle pulse: increment the selected field
- btn_down  in  1  one-cycle pulse: decrement the selected field
- btn_start  in  1  one-cycle pulse: start or resume
- btn_pause  in  1  one-cycle pulse: pause
- btn_desactivar  in  1  one-cycle pulse: abort, or clear the alarm
- out_seg  out  8  seconds, BCD 00-59
- out_min  out  8  minutes, BCD 00-59
- out_hora  out  8  hours, BCD 00-MAX_HOURS
- running  out  1  1 only in RUN
- alarm  out  1  latched alarm flag
- estado  out  3  state code: IDLE = 0, SET = 1, RUN = 2, PAUSE = 3, ALARM = 4

## Operation

- Button inputs are already debounced and edge-detected upstream. Any input high for more than one cycle acts once per high cycle.
- All outputs are registered.
- Reset values: out_seg, out_min and out_hora are 8'h00; alarm is 0; running is 0; estado is IDLE.

State transitions:
- IDLE
  - set_en = 1 → SET.
  - btn_start with a nonzero value → RUN.
  - btn_start with 00:00:00 is ignored.
- SET
  - btn_up / btn_down edit the field chosen by set_sel. set_sel = 3 means no change.
  - set_en = 0 → IDLE, keeping the edited value.
  - btn_start is ignored.
- RUN
  - Each tick_1hz decrements the BCD value with borrow (details below).
  - btn_pause → PAUSE.
  - btn_desactivar → IDLE with all fields cleared to 00.
  - set_en, btn_up and btn_down are ignored.
- PAUSE
  - The value is frozen and ticks are ignored.
  - btn_start → RUN.
  - btn_desactivar → IDLE with all fields cleared.
- ALARM
  - alarm = 1 and all fields are 00.
  - btn_desactivar → IDLE and alarm = 0.
  - All other inputs are ignored.

Edit arithmetic (BCD only; a binary value must never appear on the outputs):
- Seconds and minutes: up wraps 59 → 00; down wraps 00 → 59.
- Hours: up wraps MAX_HOURS → 00; down wraps 00 → MAX_HOURS.
- The low nibble carries into the high nibble, e.g. 09 + 1 = 10 and 10 − 1 = 09.
- btn_up and btn_down in the same cycle: no change.

Countdown arithmetic:
- If seg ≠ 00, then seg − 1.
- Otherwise seg = 59, and minutes are decremented:
  - if min ≠ 00, then min − 1;
  - otherwise min = 59 and hora − 1.
- The all-zero state is never decremented, because the FSM leaves RUN first.

Priority when events coincide:
- In RUN: btn_desactivar > btn_pause > tick_1hz. A tick arriving in the same cycle as pause or desactivar is discarded.
- In PAUSE: btn_desactivar > btn_start.

## Timing

- Every input is sampled on the rising edge of clk. The output effect is visible after that same edge (latency 1 clk).
- Expiry: the tick edge that produces 00:00:00 also moves estado to ALARM and sets alarm = 1 on that same edge. There is never a visible cycle of RUN with 00:00:00.
- A 00:00:01 value: one tick gives 00:00:00 and ALARM on the same edge.
- alarm stays high until the edge that samples btn_desactivar, then falls on that edge. It holds indefinitely without desactivar.
- running is a registered decode of the next state: high exactly in the cycles where estado = RUN.
- Reset asserted mid-operation (any state, including ALARM) forces the reset values immediately and asynchronously. After reset deasserts, nothing resumes until a new btn_start.

## Test plan

- Reset, then SET with set_sel = 1: pulse btn_up 61 times → out_min sequence passes 09 → 10 and 59 → 00, ending at 8'h01. btn_down from 00 → 8'h59.
- Program 00:01:00, btn_start, one tick → 00:00:59. 59 more ticks → 00:00:00 on the same edge as estado = 4 and alarm = 1.
- Program 01:00:00, run, one tick → 00:59:59. Hours down at 00 → MAX_HOURS (8'h23).
- RUN at 00:00:05: btn_pause and tick in the same cycle → PAUSE, value still 00:00:05. Ten ticks → unchanged. btn_start, one tick → 00:00:04.
- In ALARM, 100 cycles with no desactivar → alarm stays 1. Pulse btn_desactivar → alarm = 0, estado = 0 on that edge. btn_start at 00:00:00 → stays IDLE.
- RUN at 00:10:00: assert reset mid-cycle → outputs read 00 / 0 / IDLE asynchronously before the next clk edge. Release reset → stays IDLE.
